sample_circuit_bist: RTL

- Built-in self-test driver/checker for the 3-bit sample_circuit interface.
- It is the other end of that interface: it generates the a/b/c stimulus for the gate-level DUT and consumes its y output.
- Stimulus comes from a 9-bit LFSR; responses are compacted into a 16-bit MISR signature, which is compared to a golden value.
- Sits in the test wrapper around the synthesized netlist. The DUT is purely combinational between the BIST output registers and the MISR input.

---
 rtl/sample_circuit_bist.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sample_circuit_bist.sv
// BIST driver/checker for the 3-bit sample_circuit: a 9-bit LFSR supplies a/b/c stimulus,
// and a 16-bit MISR compacts the y responses into a signature that is compared against GOLDEN_SIG.
module sample_circuit_bist #(
    parameter int          NUM_PATTERNS = 64,
    parameter logic [8:0]  LFSR_SEED    = 9'h001,
    parameter logic [15:0] MISR_SEED    = 16'h0000,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [2:0]  dut_a,
    output logic [2:0]  dut_b,
    output logic [2:0]  dut_c,
    input  logic [2:0]  dut_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [1:0]  dbg_state
);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 511) begin : g_bad_num_patterns
        $error("sample_circuit_bist: NUM_PATTERNS must be in 1..511");
    end

    localparam logic [8:0] SEED_EFF = (LFSR_SEED == 9'd0) ? 9'h001 : LFSR_SEED;
    localparam logic [8:0] LAST_CNT = 9'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [8:0]  pattern_q;
    logic [8:0]  drive_q;
    logic [15:0] misr_q;
    logic [8:0]  count_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic [8:0]  lfsr_d;
    logic [15:0] misr_d;
    logic        misr_fb;

    // dut_y is the combinational response to the pattern driven this cycle, so it is folded in immediately.
    always_comb begin
        lfsr_d  = {pattern_q[7:0], pattern_q[8] ^ pattern_q[4]};
        misr_fb = misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3];
        misr_d  = {misr_q[14:0], misr_fb} ^ {13'b0, dut_y};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= 9'd0;
            drive_q   <= 9'd0;
            misr_q    <= 16'd0;
            count_q   <= 9'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        pattern_q <= SEED_EFF;
                        drive_q   <= SEED_EFF;
                        misr_q    <= MISR_SEED;
                        count_q   <= 9'd0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // The signature stays frozen so a debugger can inspect the partial run.
                        state_q <= ST_IDLE;
                        drive_q <= 9'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        misr_q <= misr_d;
                        if (count_q == LAST_CNT) begin
                            state_q <= ST_DONE;
                            drive_q <= 9'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (misr_d == GOLDEN_SIG);
                        end else begin
                            pattern_q <= lfsr_d;
                            drive_q   <= lfsr_d;
                            count_q   <= count_q + 9'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    drive_q <= 9'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_a     = drive_q[2:0];
    assign dut_b     = drive_q[5:3];
    assign dut_c     = drive_q[8:6];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;
    assign dbg_state = state_q;

endmodule
